// File: rtl/pipe_ctrl_if.sv
// Pipeline control bus: per-stage stall requests and exception info in, stall/flush/redirect and watchdog status out.
interface pipe_ctrl_if;
  logic        stallreq_from_if;
  logic        stallreq_from_id;
  logic        stallreq_from_ex;
  logic        stallreq_from_mem;
  logic [31:0] excepttype;
  logic [31:0] cp0_epc;
  logic        timeout_clr;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        stall_timeout;
  logic [31:0] stall_cnt;

  modport master (
    output stallreq_from_if, stallreq_from_id, stallreq_from_ex, stallreq_from_mem,
    output excepttype, cp0_epc, timeout_clr,
    input  stall, flush, new_pc, stall_timeout, stall_cnt
  );

  modport slave (
    input  stallreq_from_if, stallreq_from_id, stallreq_from_ex, stallreq_from_mem,
    input  excepttype, cp0_epc, timeout_clr,
    output stall, flush, new_pc, stall_timeout, stall_cnt
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Central 5-stage pipeline sequencer: stall vector, exception flush/redirect,
// stall-length watchdog and total-stall performance counter.
module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR  = 32'h0000_0020,
  parameter logic [15:0] STALL_LIMIT = 16'd1024,
  parameter logic [31:0] ERET_CODE   = 32'h0000_000e
) (
  input logic        clk,
  input logic        rst,
  pipe_ctrl_if.slave bus
);

  localparam int unsigned RUN_W = 16;
  localparam int unsigned CNT_W = 32;

  typedef enum logic {
    RUN,
    RECOVER
  } state_e;

  state_e             state_q, state_d;
  logic [RUN_W-1:0]   run_len_q, run_len_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic               stall_timeout_q, stall_timeout_d;

  logic [5:0]         req_stall_c;
  logic [5:0]         stall_c;
  logic               flush_c;
  logic [31:0]        new_pc_c;
  logic               stall_any_c;
  logic               limit_hit_c;

  // Later stage wins: a stalled stage freezes itself and everything upstream.
  always_comb begin
    req_stall_c = 6'b000000;
    if (bus.stallreq_from_mem)     req_stall_c = 6'b011111;
    else if (bus.stallreq_from_ex) req_stall_c = 6'b001111;
    else if (bus.stallreq_from_id) req_stall_c = 6'b000111;
    else if (bus.stallreq_from_if) req_stall_c = 6'b000011;
  end

  // In RECOVER the faulting instruction is still visible in MEM, so excepttype is ignored.
  always_comb begin
    stall_c  = 6'b000000;
    flush_c  = 1'b0;
    new_pc_c = 32'h0000_0000;
    state_d  = RUN;
    if (!rst) begin
      if (state_q == RUN && bus.excepttype != 32'h0000_0000) begin
        flush_c  = 1'b1;
        new_pc_c = (bus.excepttype == ERET_CODE) ? bus.cp0_epc : EXC_VECTOR;
        state_d  = RECOVER;
      end else begin
        stall_c  = req_stall_c;
      end
    end
  end

  always_comb begin
    stall_any_c     = |stall_c;
    stall_cnt_d     = stall_cnt_q;
    run_len_d       = '0;
    limit_hit_c     = 1'b0;
    stall_timeout_d = stall_timeout_q;
    if (stall_any_c) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
      run_len_d   = (run_len_q == STALL_LIMIT) ? run_len_q : run_len_q + RUN_W'(1);
      limit_hit_c = (run_len_q == STALL_LIMIT - RUN_W'(1));
    end
    // A set on the same edge as a clear takes precedence.
    if (limit_hit_c)          stall_timeout_d = 1'b1;
    else if (bus.timeout_clr) stall_timeout_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= RUN;
      run_len_q       <= '0;
      stall_cnt_q     <= '0;
      stall_timeout_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      run_len_q       <= run_len_d;
      stall_cnt_q     <= stall_cnt_d;
      stall_timeout_q <= stall_timeout_d;
    end
  end

  assign bus.stall         = stall_c;
  assign bus.flush         = flush_c;
  assign bus.new_pc        = new_pc_c;
  assign bus.stall_timeout = stall_timeout_q;
  assign bus.stall_cnt     = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl with a short watchdog limit (4).
module tb_pipe_ctrl;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  pipe_ctrl_if bus ();

  pipe_ctrl #(
    .EXC_VECTOR  (32'h0000_0020),
    .STALL_LIMIT (16'd4),
    .ERET_CODE   (32'h0000_000e)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.stallreq_from_if  = 1'b0;
    bus.stallreq_from_id  = 1'b0;
    bus.stallreq_from_ex  = 1'b0;
    bus.stallreq_from_mem = 1'b0;
    bus.excepttype        = 32'h0;
    bus.cp0_epc           = 32'h0;
    bus.timeout_clr       = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    #1;
    check("rst_stall", 32'(bus.stall), 32'h0);
    check("rst_flush", 32'(bus.flush), 32'h0);
    tick();
    rst = 1'b0;
    check("rst_cnt", bus.stall_cnt, 32'h0);
    check("rst_timeout", 32'(bus.stall_timeout), 32'h0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    clear_inputs();
    rst = 1'b1;
    #1;
    check("por_newpc", bus.new_pc, 32'h0);
    tick();
    do_reset();
    #1;
    check("idle_stall", 32'(bus.stall), 32'h0);
    check("idle_flush", 32'(bus.flush), 32'h0);

    // All requests, then drop mem.
    bus.stallreq_from_if  = 1'b1;
    bus.stallreq_from_id  = 1'b1;
    bus.stallreq_from_ex  = 1'b1;
    bus.stallreq_from_mem = 1'b1;
    #1;
    check("prio_mem", 32'(bus.stall), 32'h1f);
    tick();
    bus.stallreq_from_mem = 1'b0;
    #1;
    check("prio_ex", 32'(bus.stall), 32'h0f);
    bus.stallreq_from_ex = 1'b0;
    #1;
    check("prio_id", 32'(bus.stall), 32'h07);
    bus.stallreq_from_id = 1'b0;
    #1;
    check("prio_if", 32'(bus.stall), 32'h03);
    bus.stallreq_from_ex = 1'b1;
    tick();
    check("cnt_two", bus.stall_cnt, 32'd2);
    clear_inputs();
    tick();
    check("cnt_hold", bus.stall_cnt, 32'd2);

    // ID stall 3 cycles, then exception beats the stall request.
    do_reset();
    bus.stallreq_from_id = 1'b1;
    #1;
    check("id_stall", 32'(bus.stall), 32'h07);
    repeat (3) tick();
    check("id_cnt3", bus.stall_cnt, 32'd3);
    bus.excepttype = 32'h8;
    #1;
    check("exc_flush", 32'(bus.flush), 32'h1);
    check("exc_stall", 32'(bus.stall), 32'h0);
    check("exc_newpc", bus.new_pc, 32'h20);
    tick();
    check("exc_cnt", bus.stall_cnt, 32'd3);
    check("rec_flush", 32'(bus.flush), 32'h0);
    check("rec_stall", 32'(bus.stall), 32'h07);
    check("rec_newpc", bus.new_pc, 32'h0);
    tick();
    check("rec_cnt", bus.stall_cnt, 32'd4);
    check("rec_timeout", 32'(bus.stall_timeout), 32'h0);
    clear_inputs();
    tick();

    // ERET redirects to EPC; RECOVER masks the stale code for one cycle.
    do_reset();
    bus.excepttype = 32'he;
    bus.cp0_epc    = 32'hBFC0_0100;
    #1;
    check("eret_flush", 32'(bus.flush), 32'h1);
    check("eret_newpc", bus.new_pc, 32'hBFC0_0100);
    tick();
    check("eret_rec_flush", 32'(bus.flush), 32'h0);
    check("eret_rec_stall", 32'(bus.stall), 32'h0);
    tick();
    check("eret_again", 32'(bus.flush), 32'h1);
    check("eret_again_pc", bus.new_pc, 32'hBFC0_0100);
    check("eret_cnt", bus.stall_cnt, 32'd0);
    clear_inputs();
    tick();

    // Watchdog: rises on 4th consecutive stalled edge, cleared by pulse.
    do_reset();
    bus.stallreq_from_mem = 1'b1;
    repeat (3) tick();
    check("wd_before", 32'(bus.stall_timeout), 32'h0);
    tick();
    check("wd_set", 32'(bus.stall_timeout), 32'h1);
    tick();
    check("wd_sticky", 32'(bus.stall_timeout), 32'h1);
    check("wd_cnt5", bus.stall_cnt, 32'd5);
    bus.stallreq_from_mem = 1'b0;
    bus.timeout_clr       = 1'b1;
    tick();
    bus.timeout_clr = 1'b0;
    check("wd_clr", 32'(bus.stall_timeout), 32'h0);
    check("wd_cnt_after", bus.stall_cnt, 32'd5);

    // Set and clear on the same edge: set wins.
    do_reset();
    bus.stallreq_from_ex = 1'b1;
    repeat (3) tick();
    bus.timeout_clr = 1'b1;
    tick();
    check("wd_set_wins", 32'(bus.stall_timeout), 32'h1);
    bus.timeout_clr = 1'b0;
    bus.stallreq_from_ex = 1'b0;
    tick();

    // Stall broken by a flush restarts the run length.
    do_reset();
    bus.stallreq_from_if = 1'b1;
    repeat (3) tick();
    bus.excepttype = 32'h4;
    tick();
    bus.excepttype = 32'h0;
    repeat (3) tick();
    check("wd_restart", 32'(bus.stall_timeout), 32'h0);
    check("wd_restart_cnt", bus.stall_cnt, 32'd6);
    clear_inputs();

    // Asynchronous reset mid-stall.
    do_reset();
    bus.stallreq_from_mem = 1'b1;
    repeat (7) tick();
    check("mid_cnt7", bus.stall_cnt, 32'd7);
    #2;
    rst = 1'b1;
    #1;
    check("async_stall", 32'(bus.stall), 32'h0);
    check("async_cnt", bus.stall_cnt, 32'h0);
    check("async_timeout", 32'(bus.stall_timeout), 32'h0);
    clear_inputs();
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_cnt", bus.stall_cnt, 32'h0);

    // Asynchronous reset mid-RECOVER returns to RUN.
    bus.excepttype = 32'h8;
    tick();
    check("pre_rst_rec", 32'(bus.flush), 32'h0);
    #2;
    rst = 1'b1;
    #1;
    check("rst_rec_flush", 32'(bus.flush), 32'h0);
    tick();
    rst = 1'b0;
    #1;
    check("run_after_rst", 32'(bus.flush), 32'h1);
    check("run_after_pc", bus.new_pc, 32'h20);
    clear_inputs();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
